// File: rtl/mdcd_pkg.sv
// Shared types and constants for the multiplexed counter display: digit type,
// number bases and the seven-segment glyph table ({a,b,c,d,e,f,g}, active-high).
package mdcd_pkg;

  typedef logic [3:0] digit_t;

  localparam int BASE_HEX = 16;
  localparam int BASE_DEC = 10;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Indexed by digit value; b and d are the lowercase forms.
  localparam logic [6:0] GLYPHS [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex-to-seven-segment decoder, active-high {a,b,c,d,e,f,g}.
module seven_seg_decode
  import mdcd_pkg::*;
(
  input  digit_t      i_val,
  output logic [6:0]  o_seg
);

  assign o_seg = GLYPHS[i_val];

endmodule

// File: rtl/multi_digit_counter_display.sv
// Multi-digit cursor counter with multiplexed seven-segment scan.
// Optional cursor blinking is enabled by defining CURSOR_BLINK_EN.
module multi_digit_counter_display
  import mdcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          move,
  input  logic                          count,
  input  logic                          dec_mode,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] cursor,
  output logic                          overflow
);

  localparam int CW = $clog2(NUM_DIGITS);
  localparam int DW = $clog2(SCAN_DIV);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_param
    $error("multi_digit_counter_display: parameter out of range");
  end

  logic [NUM_DIGITS-1:0][3:0] r_digits;
  logic [NUM_DIGITS-1:0][3:0] w_digits_nx;
  logic [CW-1:0]              r_cursor;
  logic [CW-1:0]              r_scan;
  logic [DW-1:0]              r_div;
  logic                       r_move_q;
  logic                       r_count_q;
  logic                       r_overflow;
  logic [6:0]                 r_seg;
  logic [NUM_DIGITS-1:0]      r_an;

  logic   w_move_ev;
  logic   w_count_ev;
  logic   w_top_cy;
  digit_t w_base_m1;
  digit_t w_scan_val;
  logic [6:0] w_glyph;
  logic   w_blank;

  assign w_move_ev  = move  & ~r_move_q;
  assign w_count_ev = count & ~r_count_q;
  assign w_base_m1  = dec_mode ? digit_t'(BASE_DEC - 1) : digit_t'(BASE_HEX - 1);

  // Ripple from the cursor upward; ">=" also folds hex leftovers in decimal mode.
  always_comb begin
    logic cy;
    logic inc;
    w_digits_nx = r_digits;
    cy          = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      inc = cy | (w_count_ev & (r_cursor == CW'(i)));
      cy  = 1'b0;
      if (inc) begin
        if (r_digits[i] >= w_base_m1) begin
          w_digits_nx[i] = 4'd0;
          cy             = 1'b1;
        end else begin
          w_digits_nx[i] = r_digits[i] + 4'd1;
        end
      end
    end
    w_top_cy = cy;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_digits   <= '0;
      r_cursor   <= '0;
      r_move_q   <= 1'b0;
      r_count_q  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_digits   <= w_digits_nx;
      r_move_q   <= move;
      r_count_q  <= count;
      r_overflow <= w_top_cy;
      if (w_move_ev)
        r_cursor <= (r_cursor == CW'(NUM_DIGITS - 1)) ? '0 : r_cursor + CW'(1);
    end
  end

  assign w_scan_val = r_digits[r_scan];

  seven_seg_decode u_dec (
    .i_val (w_scan_val),
    .o_seg (w_glyph)
  );

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  // Edits restart the blink so the touched digit shows immediately.
  always_ff @(posedge clock) begin
    if (reset || w_move_ev || w_count_ev) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign w_blank = r_phase & (r_scan == r_cursor);
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div  <= '0;
      r_scan <= '0;
      r_seg  <= GLYPHS[0];
      r_an   <= ~NUM_DIGITS'(1);
    end else begin
      if (r_div == DW'(SCAN_DIV - 1)) begin
        r_div  <= '0;
        r_scan <= (r_scan == CW'(NUM_DIGITS - 1)) ? '0 : r_scan + CW'(1);
      end else begin
        r_div <= r_div + DW'(1);
      end
      r_seg <= w_blank ? SEG_BLANK : w_glyph;
      r_an  <= ~(NUM_DIGITS'(1) << r_scan);
    end
  end

  assign seg      = r_seg;
  assign an       = r_an;
  assign cursor   = r_cursor;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Randomized bench with an arithmetic reference model of the counter display,
// compared every cycle, plus directed scenarios with literal expectations.
module tb_multi_digit_counter_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic move = 1'b0, count = 1'b0, dec_mode = 1'b0;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [1:0]    cursor;
  logic          overflow;

  multi_digit_counter_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clock(clock), .reset(reset), .move(move), .count(count), .dec_mode(dec_mode),
    .seg(seg), .an(an), .cursor(cursor), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  logic [6:0] GL [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference model state
  int md[ND];
  int mcur, mscan, mdiv, mbc;
  bit mph, mpm, mpc, mov;
  logic [6:0]    mseg;
  logic [ND-1:0] man;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clock) begin : model
    bit em, ec, cy;
    int c, base;
    if (reset) begin
      foreach (md[i]) md[i] = 0;
      mcur = 0; mscan = 0; mdiv = 0; mbc = 0;
      mph = 0; mpm = 0; mpc = 0; mov = 0;
      mseg = GL[0];
      man  = '1; man[0] = 1'b0;
    end else begin
      em = move && !mpm;
      ec = count && !mpc;
      mseg = GL[md[mscan]];
`ifdef CURSOR_BLINK_EN
      if (mph && mscan == mcur) mseg = 7'b0;
`endif
      for (int i = 0; i < ND; i++) man[i] = (i != mscan);
      mov = 0;
      if (ec) begin
        base = dec_mode ? 10 : 16;
        c = mcur; cy = 1;
        while (cy && c < ND) begin
          if (md[c] + 1 >= base) begin md[c] = 0; c++; end
          else begin md[c] = md[c] + 1; cy = 0; end
        end
        mov = cy;
      end
      if (em) mcur = (mcur + 1) % ND;
      if (mdiv == SD - 1) begin mdiv = 0; mscan = (mscan + 1) % ND; end
      else mdiv++;
      if (em || ec) begin mbc = 0; mph = 0; end
      else if (mbc == BD - 1) begin mbc = 0; mph = !mph; end
      else mbc++;
      mpm = move; mpc = count;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("seg", 32'(seg), 32'(mseg));
      chk("an", 32'(an), 32'(man));
      chk("cursor", 32'(cursor), 32'(mcur));
      chk("overflow", 32'(overflow), 32'(mov));
    end
  end

  task automatic pulse_count();
    @(negedge clock) count = 1'b1;
    @(negedge clock) count = 1'b0;
  endtask

  task automatic pulse_move();
    @(negedge clock) move = 1'b1;
    @(negedge clock) move = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    @(negedge clock) reset = 1'b0;
  endtask

  // Wait (bounded) until digit idx is being driven, then check its glyph.
  task automatic scan_seg(input string nm, input int idx, input logic [6:0] exp);
    bit found = 0;
    logic [ND-1:0] want;
    want = '1; want[idx] = 1'b0;
    for (int k = 0; k < 4 * SD * ND && !found; k++) begin
      @(negedge clock); #1;
      if (an === want) found = 1;
    end
    if (!found) chk({nm, "_timeout"}, 32'(an), 32'(want));
    else chk(nm, 32'(seg), 32'(exp));
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    reset  = 1'b0;
    #1;
    chk("rst_seg", 32'(seg), 32'h7E);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_cursor", 32'(cursor), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (5) @(negedge clock);
    #1 chk("scan_an1", 32'(an), 32'hD);

    // Held count gives one event only
    @(negedge clock) count = 1'b1;
    repeat (10) @(negedge clock);
    count = 1'b0;
    chk("model_hold_d0", md[0], 1);
    scan_seg("hold_d0", 0, 7'b0110000);
    scan_seg("hold_d1", 1, 7'b1111110);
    repeat (14) pulse_count();
    scan_seg("hex_F", 0, 7'b1000111);
    pulse_count();
    scan_seg("wrap_d0", 0, 7'b1111110);
    scan_seg("wrap_d1", 1, 7'b0110000);

    // Decimal 9999 + 1 overflows
    do_reset();
    dec_mode = 1'b1;
    for (int p = 0; p < ND; p++) begin
      repeat (9) pulse_count();
      pulse_move();
    end
    chk("model_9999", md[0] * 1000 + md[1] * 100 + md[2] * 10 + md[3], 9999);
    @(negedge clock) count = 1'b1;
    @(negedge clock) count = 1'b0;
    #1 chk("dec_ovf_hi", 32'(overflow), 32'd1);
    @(negedge clock);
    #1 chk("dec_ovf_lo", 32'(overflow), 32'd0);
    for (int p = 0; p < ND; p++) scan_seg("dec_zero", p, 7'b1111110);
    dec_mode = 1'b0;

    // Simultaneous move and count
    do_reset();
    pulse_move();
    repeat (3) pulse_count();
    @(negedge clock) begin move = 1'b1; count = 1'b1; end
    @(negedge clock) begin move = 1'b0; count = 1'b0; end
    #1 chk("sim_cursor", 32'(cursor), 32'd2);
    scan_seg("sim_d1", 1, 7'b0110011);
    pulse_move();
    pulse_move();
    #1 chk("cursor_wrap", 32'(cursor), 32'd0);

    // Reset on the carry cycle of 0xFFFF
    do_reset();
    for (int p = 0; p < ND; p++) begin
      repeat (15) pulse_count();
      if (p < ND - 1) pulse_move();
    end
    @(negedge clock) begin count = 1'b1; reset = 1'b1; end
    @(negedge clock) begin count = 1'b0; reset = 1'b0; end
    #1 chk("rstcy_ovf", 32'(overflow), 32'd0);
    for (int p = 0; p < ND; p++) scan_seg("rstcy_zero", p, 7'b1111110);

    // Random traffic, including mode flips that leave hex digits in decimal mode
    repeat (3000) begin
      @(negedge clock);
      move  = ($urandom_range(0, 3) == 0);
      count = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) dec_mode = ~dec_mode;
      reset = ($urandom_range(0, 499) == 0);
    end
    @(negedge clock) begin reset = 1'b0; move = 1'b0; count = 1'b0; end
    repeat (4) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
